abc_input_conditioner: RTL and testbench

Front-end conditioner for the three asynchronous condition inputs that drive the a&b&c-qualified state sequencer. It synchronizes each raw input into the `clk` domain and debounces it per bit. It then presents clean, registered levels `a`, `b`, `c` to the sequencer, plus convenience flags and a saturating glitch counter for diagnostics.

---
 rtl/abc_input_conditioner.sv | 102 ++++++++++
 tb/tb_abc_input_conditioner.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abc_input_conditioner.sv
// Synchronizes and debounces the a/b/c condition inputs for the sequencer, with
// registered levels, all-high/change flags and a saturating glitch counter.
module abc_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       c_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       all_high,
    output logic       all_high_rise,
    output logic       change,
    output logic [7:0] glitch_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             s;
    logic [2:0]             o_q, o_d;
    logic [CntW-1:0]        cnt_q [3];
    logic [CntW-1:0]        cnt_d [3];
    logic [2:0]             glitch, upd;
    logic                   change_q, all_high_d_q;
    logic [1:0]             glitch_sum;
    logic [8:0]             glitch_acc;
    logic [7:0]             glitch_count_q, glitch_count_d;

    assign raw = {c_in, b_in, a_in};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Per-bit debounce: a return to the held level with a pending count is a glitch.
    always_comb begin
        o_d    = o_q;
        glitch = '0;
        upd    = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == o_q[i]) begin
                if (cnt_q[i] != '0) begin
                    glitch[i] = 1'b1;
                    cnt_d[i]  = '0;
                end
            end else if (cnt_q[i] == CntMax) begin
                o_d[i]   = s[i];
                cnt_d[i] = '0;
                upd[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        glitch_sum     = {1'b0, glitch[0]} + {1'b0, glitch[1]} + {1'b0, glitch[2]};
        glitch_acc     = {1'b0, glitch_count_q} + {7'b0, glitch_sum};
        glitch_count_d = glitch_acc[8] ? 8'hFF : glitch_acc[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            o_q            <= '0;
            change_q       <= 1'b0;
            all_high_d_q   <= 1'b0;
            glitch_count_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            o_q            <= o_d;
            change_q       <= |upd;
            all_high_d_q   <= &o_q;
            glitch_count_q <= glitch_count_d;
        end
    end

    assign a             = o_q[0];
    assign b             = o_q[1];
    assign c             = o_q[2];
    assign all_high      = &o_q;
    assign all_high_rise = all_high & ~all_high_d_q;
    assign change        = change_q;
    assign glitch_count  = glitch_count_q;

endmodule

// File: tb/tb_abc_input_conditioner.sv
// Directed and randomized checks of abc_input_conditioner against a
// run-length debounce model with a raw-sample delay line.
module tb_abc_input_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_in = 1'b0, b_in = 1'b0, c_in = 1'b0;
    logic       a, b, c, all_high, all_high_rise, change;
    logic [7:0] glitch_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw history per bit, accepted level, run length.
    logic       m_hist [3][SYNC];
    logic [2:0] m_o;
    int         m_run [3];
    int         m_gc;
    logic       m_chg;
    logic       m_ahd;

    always #5 clk = ~clk;

    abc_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a_in          (a_in),
        .b_in          (b_in),
        .c_in          (c_in),
        .a             (a),
        .b             (b),
        .c             (c),
        .all_high      (all_high),
        .all_high_rise (all_high_rise),
        .change        (change),
        .glitch_count  (glitch_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < SYNC; j++) m_hist[i][j] = 1'b0;
            m_run[i] = 0;
        end
        m_o   = '0;
        m_gc  = 0;
        m_chg = 1'b0;
        m_ahd = 1'b0;
    endtask

    // A level is accepted once it has differed from the output for DEB
    // consecutive synchronized cycles; a shorter run ending is one glitch.
    task automatic model_step();
        logic [2:0] raw;
        logic       s;
        logic       ah;
        int         ng;
        logic       upd;
        raw = {c_in, b_in, a_in};
        ah  = &m_o;
        ng  = 0;
        upd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = m_hist[i][SYNC-1];
            if (s != m_o[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB) begin
                    m_o[i]   = s;
                    m_run[i] = 0;
                    upd      = 1'b1;
                end
            end else begin
                if (m_run[i] != 0) ng = ng + 1;
                m_run[i] = 0;
            end
            for (int j = SYNC - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = raw[i];
        end
        m_gc  = (m_gc + ng > 255) ? 255 : m_gc + ng;
        m_chg = upd;
        m_ahd = ah;
    endtask

    function automatic logic [13:0] model_vec();
        logic [7:0] g;
        g = m_gc[7:0];
        return {m_o[0], m_o[1], m_o[2], &m_o, (&m_o) & ~m_ahd, m_chg, g};
    endfunction

    // Advance one edge; returns at the following falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {a_in, b_in, c_in} = 3'b111;
        model_reset();
        repeat (3) tick();
        checks++;
        if ({a, b, c, all_high, all_high_rise, change, glitch_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {a, b, c, all_high, all_high_rise, change, glitch_count});
        end
    endtask

    task automatic test_all_high();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) begin
                checks++;
                if ({a, b, c, change} !== 4'b0000) begin
                    errors++;
                    $display("FAIL early_accept edge %0d got abc=%b chg=%b want 0", e,
                             {a, b, c}, change);
                end
            end else if (e == 6) begin
                checks++;
                if ({a, b, c, all_high, all_high_rise, change, glitch_count}
                    !== {6'b111111, 8'd0}) begin
                    errors++;
                    $display("FAIL accept_111 got abc=%b ah=%b rise=%b chg=%b gc=%0d want 1111110",
                             {a, b, c}, all_high, all_high_rise, change, glitch_count);
                end
            end else begin
                checks++;
                if ({a, b, c, all_high, all_high_rise, change} !== 6'b111100) begin
                    errors++;
                    $display("FAIL pulse_width got abc=%b ah=%b rise=%b chg=%b want 111100",
                             {a, b, c}, all_high, all_high_rise, change);
                end
            end
        end
        {a_in, b_in, c_in} = 3'b000;
        repeat (8) tick();
        checks++;
        if ({a, b, c, all_high} !== 4'b0000) begin
            errors++;
            $display("FAIL return_000 got abc=%b ah=%b want 0", {a, b, c}, all_high);
        end
    endtask

    task automatic test_short_glitch();
        logic [7:0] gc0;
        int         nchg;
        logic       bseen;
        gc0   = glitch_count;
        nchg  = 0;
        bseen = 1'b0;
        b_in  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 2) b_in = 1'b0;
            nchg  += int'(change);
            bseen |= b;
        end
        checks++;
        if (bseen !== 1'b0 || nchg != 0 || glitch_count !== gc0 + 8'd1) begin
            errors++;
            $display("FAIL short_glitch got b_seen=%b changes=%0d gc=%0d want 0 0 %0d",
                     bseen, nchg, glitch_count, gc0 + 8'd1);
        end
    endtask

    task automatic test_exact_pulse();
        logic [7:0] gc0;
        int         nchg;
        logic       exp_b;
        gc0  = glitch_count;
        nchg = 0;
        b_in = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 4) b_in = 1'b0;
            exp_b = (e >= 6 && e <= 9);
            nchg += int'(change);
            checks++;
            if (b !== exp_b) begin
                errors++;
                $display("FAIL exact_pulse edge %0d got b=%b want %b", e, b, exp_b);
            end
        end
        checks++;
        if (nchg != 2 || glitch_count !== gc0) begin
            errors++;
            $display("FAIL exact_pulse_flags got changes=%0d gc=%0d want 2 %0d",
                     nchg, glitch_count, gc0);
        end
    endtask

    task automatic test_dual_glitch();
        logic [7:0] gc0, prev;
        int         maxd;
        logic       seen;
        gc0  = glitch_count;
        maxd = 0;
        seen = 1'b0;
        a_in = 1'b1;
        c_in = 1'b1;
        repeat (2) tick();
        a_in = 1'b0;
        c_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            prev = glitch_count;
            tick();
            if (int'(glitch_count) - int'(prev) > maxd) maxd = int'(glitch_count) - int'(prev);
            seen |= a | c;
        end
        checks++;
        if (maxd != 2 || glitch_count !== gc0 + 8'd2 || seen !== 1'b0) begin
            errors++;
            $display("FAIL dual_glitch got max_step=%0d gc=%0d ac_seen=%b want 2 %0d 0",
                     maxd, glitch_count, seen, gc0 + 8'd2);
        end
    endtask

    task automatic test_saturate();
        logic aseen;
        aseen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            a_in = 1'b1;
            tick();
            a_in = 1'b0;
            repeat (7) begin
                tick();
                aseen |= a;
            end
        end
        checks++;
        if (glitch_count !== 8'd255 || aseen !== 1'b0) begin
            errors++;
            $display("FAIL saturate got gc=%0d a_seen=%b want 255 0", glitch_count, aseen);
        end
        checks++;
        if ({a, b, c, all_high, all_high_rise, change, glitch_count} !== model_vec()) begin
            errors++;
            $display("FAIL saturate_model got %h want %h",
                     {a, b, c, all_high, all_high_rise, change, glitch_count}, model_vec());
        end
    endtask

    task automatic test_async_reset();
        a_in = 1'b1;
        repeat (8) tick();
        c_in = 1'b1;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({a, b, c, all_high, all_high_rise, change, glitch_count} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0",
                     {a, b, c, all_high, all_high_rise, change, glitch_count});
        end
        @(negedge clk);
        reset = 1'b0;
        a_in  = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (c !== (e >= 6)) begin
                errors++;
                $display("FAIL reacquire edge %0d got c=%b want %b", e, c, (e >= 6));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) a_in = ~a_in;
            if ($urandom_range(0, 5) == 0) b_in = ~b_in;
            if ($urandom_range(0, 5) == 0) c_in = ~c_in;
            tick();
            checks++;
            if ({a, b, c, all_high, all_high_rise, change, glitch_count} !== model_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h", n,
                         {a, b, c, all_high, all_high_rise, change, glitch_count}, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_high();
        test_short_glitch();
        test_exact_pulse();
        test_dual_glitch();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
